// File: rtl/eth_pkg.sv
// Shared types and constants for the receive-side Ethernet frame parser.
// Holds the FSM state encoding, error codes and the header record.
package eth_pkg;

   typedef enum logic [1:0] {
      S_PREAMBLE = 2'd0,
      S_HEADER   = 2'd1,
      S_PAYLOAD  = 2'd2,
      S_DROP     = 2'd3
   } parser_state_e;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;
   localparam int         ETH_HDR_LEN   = 14;

   typedef enum logic [1:0] {
      ERR_PREAMBLE = 2'd0,
      ERR_RUNT     = 2'd1,
      ERR_OVERSIZE = 2'd2
   } eth_err_e;

   typedef struct packed {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] ethertype;
   } eth_hdr_t;

endpackage

// File: rtl/byte_skid_fifo.sv
// Two-entry output buffer for {err, last, data} payload entries.
// Output entry holds stable while out_valid is high and out_ready is low.
module byte_skid_fifo #(
   parameter int W = 10
) (
   input  logic         rclk,
   input  logic         rrst_n,
   input  logic         push,
   input  logic [W-1:0] push_entry,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_entry,
   output logic [1:0]   occ
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         pop;

   assign out_valid = (occ != 2'd0);
   assign pop       = out_valid && out_ready;
   assign out_entry = mem[rd_ptr];

   // The producer never pushes into a full buffer; its pop rule reserves room.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= !wr_ptr;
         end
         if (pop) rd_ptr <= !rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/eth_rx_parser.sv
// Pops tagged bytes from the ingress FIFO, checks preamble/SFD, extracts the
// MAC/EtherType header and forwards payload on a valid/ready byte stream.
module eth_rx_parser
   import eth_pkg::*;
#(
   parameter int unsigned MIN_PREAMBLE = 1,
   parameter int unsigned MAX_FRAME    = 1518,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   input  logic                 fifo_empty,
   input  logic [8:0]           fifo_data,
   output logic                 fifo_ren,
   output logic                 hdr_valid,
   output logic [47:0]          hdr_dst_mac,
   output logic [47:0]          hdr_src_mac,
   output logic [15:0]          hdr_ethertype,
   // Payload handshake: a byte transfers on a rising rclk edge where
   // out_valid && out_ready; while out_valid && !out_ready the entry holds.
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [7:0]           out_data,
   output logic                 out_last,
   output logic                 out_err,
   output logic                 frame_err,
   output logic [1:0]           err_code,
   output logic [CNT_WIDTH-1:0] frame_cnt,
   output logic [CNT_WIDTH-1:0] err_cnt,
   output logic [1:0]           dbg_state
);

   localparam int         BCW     = $clog2(MAX_FRAME + 1);
   localparam logic [3:0] MIN_PRE = 4'(MIN_PREAMBLE);

   parser_state_e  state;
   logic [2:0]     pre_cnt;
   logic [BCW-1:0] byte_cnt;
   logic           inflight;
   logic           active;
   eth_hdr_t       hdr;

   logic [7:0]     rx_byte;
   logic           rx_last;
   logic           at_max;
   logic           push;
   logic [9:0]     push_entry;
   logic [9:0]     out_entry;
   logic [1:0]     occ;
   logic           pop;
   logic [2:0]     room_need;

   assign rx_byte    = fifo_data[7:0];
   assign rx_last    = fifo_data[8];
   assign at_max     = (byte_cnt == BCW'(MAX_FRAME - 1));
   assign push       = inflight && (state == S_PAYLOAD);
   assign push_entry = {at_max && !rx_last, rx_last || at_max, rx_byte};
   assign pop        = out_valid && out_ready;

   // Room check counts the byte already in flight from the FIFO, whose read
   // data arrives one cycle after fifo_ren.
   assign room_need = {1'b0, occ} - {2'b0, pop} + {2'b0, inflight};
   assign fifo_ren  = active && !fifo_empty && (room_need < 3'd2);

   assign hdr_dst_mac   = hdr.dst;
   assign hdr_src_mac   = hdr.src;
   assign hdr_ethertype = hdr.ethertype;
   assign dbg_state     = state;
   assign out_data      = out_entry[7:0];
   assign out_last      = out_entry[8];
   assign out_err       = out_entry[9];

   byte_skid_fifo #(.W(10)) u_skid (
      .rclk       (rclk),
      .rrst_n     (rrst_n),
      .push       (push),
      .push_entry (push_entry),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_entry  (out_entry),
      .occ        (occ)
   );

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state     <= S_PREAMBLE;
         pre_cnt   <= 3'd0;
         byte_cnt  <= '0;
         inflight  <= 1'b0;
         active    <= 1'b0;
         hdr       <= '0;
         hdr_valid <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'd0;
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         active    <= 1'b1;
         inflight  <= fifo_ren;
         hdr_valid <= 1'b0;
         frame_err <= 1'b0;
         if (inflight) begin
            case (state)
               S_PREAMBLE: begin
                  if (rx_byte == PREAMBLE_BYTE) begin
                     if (rx_last)              pre_cnt <= 3'd0;
                     else if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
                  end else if (rx_byte == SFD_BYTE && {1'b0, pre_cnt} >= MIN_PRE) begin
                     pre_cnt <= 3'd0;
                     // A frame ending on its SFD carries no header at all.
                     if (rx_last) begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_RUNT;
                        err_cnt   <= err_cnt + CNT_WIDTH'(1);
                     end else begin
                        state    <= S_HEADER;
                        byte_cnt <= '0;
                     end
                  end else begin
                     pre_cnt   <= 3'd0;
                     frame_err <= 1'b1;
                     err_code  <= ERR_PREAMBLE;
                     err_cnt   <= err_cnt + CNT_WIDTH'(1);
                     if (!rx_last) state <= S_DROP;
                  end
               end
               S_HEADER: begin
                  if (byte_cnt < BCW'(6))       hdr.dst       <= {hdr.dst[39:0], rx_byte};
                  else if (byte_cnt < BCW'(12)) hdr.src       <= {hdr.src[39:0], rx_byte};
                  else                          hdr.ethertype <= {hdr.ethertype[7:0], rx_byte};
                  byte_cnt <= byte_cnt + BCW'(1);
                  if (rx_last) begin
                     state     <= S_PREAMBLE;
                     frame_err <= 1'b1;
                     err_code  <= ERR_RUNT;
                     err_cnt   <= err_cnt + CNT_WIDTH'(1);
                  end else if (byte_cnt == BCW'(ETH_HDR_LEN - 1)) begin
                     state     <= S_PAYLOAD;
                     hdr_valid <= 1'b1;
                  end
               end
               S_PAYLOAD: begin
                  byte_cnt <= byte_cnt + BCW'(1);
                  if (rx_last) begin
                     state     <= S_PREAMBLE;
                     frame_cnt <= frame_cnt + CNT_WIDTH'(1);
                  end else if (at_max) begin
                     state     <= S_DROP;
                     frame_err <= 1'b1;
                     err_code  <= ERR_OVERSIZE;
                     err_cnt   <= err_cnt + CNT_WIDTH'(1);
                  end
               end
               S_DROP: begin
                  if (rx_last) state <= S_PREAMBLE;
               end
               default: state <= S_PREAMBLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_eth_rx_parser.sv
// Directed bench for eth_rx_parser: a default-size instance for the main
// cases and a MAX_FRAME=20 instance for the oversize case.
module tb_eth_rx_parser;
   import eth_pkg::*;

   logic rclk = 1'b0;
   logic rrst_n = 1'b0;
   logic fifo_empty = 1'b1;
   logic [8:0] fifo_data = '0;
   logic out_ready = 1'b0;
   logic sel_b = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 rclk = ~rclk;

   logic a_empty, b_empty;
   assign a_empty = fifo_empty | sel_b;
   assign b_empty = fifo_empty | ~sel_b;

   logic        a_ren, a_hv, a_ov, a_ol, a_oe, a_fe;
   logic [47:0] a_dst, a_src;
   logic [15:0] a_et, a_fc, a_ec;
   logic [7:0]  a_od;
   logic [1:0]  a_code, a_st;
   logic        b_ren, b_hv, b_ov, b_ol, b_oe, b_fe;
   logic [47:0] b_dst, b_src;
   logic [15:0] b_et, b_fc, b_ec;
   logic [7:0]  b_od;
   logic [1:0]  b_code, b_st;

   eth_rx_parser dut_a (
      .rclk(rclk), .rrst_n(rrst_n), .fifo_empty(a_empty), .fifo_data(fifo_data),
      .fifo_ren(a_ren), .hdr_valid(a_hv), .hdr_dst_mac(a_dst), .hdr_src_mac(a_src),
      .hdr_ethertype(a_et), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
      .out_last(a_ol), .out_err(a_oe), .frame_err(a_fe), .err_code(a_code),
      .frame_cnt(a_fc), .err_cnt(a_ec), .dbg_state(a_st)
   );

   eth_rx_parser #(.MAX_FRAME(20)) dut_b (
      .rclk(rclk), .rrst_n(rrst_n), .fifo_empty(b_empty), .fifo_data(fifo_data),
      .fifo_ren(b_ren), .hdr_valid(b_hv), .hdr_dst_mac(b_dst), .hdr_src_mac(b_src),
      .hdr_ethertype(b_et), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
      .out_last(b_ol), .out_err(b_oe), .frame_err(b_fe), .err_code(b_code),
      .frame_cnt(b_fc), .err_cnt(b_ec), .dbg_state(b_st)
   );

   logic        m_ren, m_hv, m_ov, m_fe;
   logic [9:0]  m_entry;
   logic [1:0]  m_code, m_occ, m_st;
   logic [15:0] m_fc, m_ec;
   eth_hdr_t    m_hdr;
   assign m_ren   = sel_b ? b_ren : a_ren;
   assign m_hv    = sel_b ? b_hv : a_hv;
   assign m_ov    = sel_b ? b_ov : a_ov;
   assign m_fe    = sel_b ? b_fe : a_fe;
   assign m_code  = sel_b ? b_code : a_code;
   assign m_fc    = sel_b ? b_fc : a_fc;
   assign m_ec    = sel_b ? b_ec : a_ec;
   assign m_st    = sel_b ? b_st : a_st;
   assign m_entry = sel_b ? {b_oe, b_ol, b_od} : {a_oe, a_ol, a_od};
   assign m_hdr   = sel_b ? {b_dst, b_src, b_et} : {a_dst, a_src, a_et};
   assign m_occ   = sel_b ? dut_b.u_skid.occ : dut_a.u_skid.occ;

   // Upstream FIFO model: one-cycle read latency, random read data in reset.
   logic [8:0] fq[$];
   always @(posedge rclk) begin
      if (!rrst_n) fifo_data <= 9'($urandom);
      else if (m_ren) fifo_data <= fq.pop_front();
      fifo_empty <= (fq.size() == 0);
   end

   // Scoreboard state gathered on the falling edge.
   logic [9:0] got_q[$];
   logic [9:0] exp_q[$];
   logic [1:0] code_q[$];
   int         hdr_n, ren_gap, occ_max, stab_err;
   eth_hdr_t   hdr_cap;
   logic       hold;
   logic [9:0] hold_entry;

   always @(negedge rclk) begin
      if (rrst_n) begin
         if (m_ov && out_ready) got_q.push_back(m_entry);
         if (m_hv) begin
            hdr_n++;
            hdr_cap = m_hdr;
         end
         if (m_fe) code_q.push_back(m_code);
         if (!fifo_empty && !m_ren) ren_gap++;
         if (int'(m_occ) > occ_max) occ_max = int'(m_occ);
         if (hold && m_ov && m_entry !== hold_entry) stab_err++;
         hold       = m_ov && !out_ready;
         hold_entry = m_entry;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      got_q.delete();
      exp_q.delete();
      code_q.delete();
      hdr_n = 0; ren_gap = 0; occ_max = 0; stab_err = 0; hold = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge rclk);
      #1;
   endtask

   task automatic add(input logic [8:0] v);
      fq.push_back(v);
   endtask

   // Preamble x7, SFD, fixed header, payload base + step*i with last on the final byte.
   task automatic add_good(input int n_pay, input logic [7:0] base, input logic [7:0] step);
      repeat (7) add(9'h055);
      add(9'h0D5);
      for (int i = 0; i < 6; i++) add({1'b0, 8'(i + 1)});
      for (int i = 0; i < 6; i++) add({1'b0, 8'(i + 10)});
      add(9'h008);
      add(9'h000);
      for (int i = 0; i < n_pay; i++) add({i == n_pay - 1, base + 8'(i) * step});
   endtask

   task automatic exp_stream(input int n, input logic [7:0] base, input logic [7:0] step);
      for (int i = 0; i < n; i++) exp_q.push_back({1'b0, i == n - 1, base + 8'(i) * step});
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), (i < got_q.size()) ? 64'(got_q[i]) : 64'hdead, 64'(exp_q[i]));
   endtask

   task automatic check_good_hdr(input string tag);
      check({tag, "_hdr_n"}, 64'(hdr_n), 64'd1);
      check({tag, "_dst"}, 64'(hdr_cap.dst), 64'h010203040506);
      check({tag, "_src"}, 64'(hdr_cap.src), 64'h0A0B0C0D0E0F);
      check({tag, "_type"}, 64'(hdr_cap.ethertype), 64'h0800);
   endtask

   task automatic do_reset();
      rrst_n = 1'b0;
      repeat (4) begin
         add(9'($urandom));
         out_ready = 1'($urandom);
         @(posedge rclk);
         #1;
      end
      fq.delete();
      run(2);
      rrst_n = 1'b1;
      out_ready = 1'b1;
      run(3);
      clr_mon();
   endtask

   initial begin
      // Reset with random stimulus; outputs checked while still in reset.
      rrst_n = 1'b0;
      repeat (3) begin
         add(9'($urandom));
         out_ready = 1'($urandom);
         @(posedge rclk);
         #1;
      end
      @(negedge rclk);
      check("rst_ren", 64'(a_ren), 64'd0);
      check("rst_ren_b", 64'(b_ren), 64'd0);
      check("rst_hdr_valid", 64'(a_hv), 64'd0);
      check("rst_hdr", 64'({a_dst, a_src, a_et}), 64'd0);
      check("rst_out_valid", 64'(a_ov), 64'd0);
      check("rst_out", 64'({a_oe, a_ol, a_od}), 64'd0);
      check("rst_frame_err", 64'({a_fe, a_code}), 64'd0);
      check("rst_frame_cnt", 64'(a_fc), 64'd0);
      check("rst_err_cnt", 64'(a_ec), 64'd0);
      check("rst_state", 64'(a_st), 64'(S_PREAMBLE));
      do_reset();

      // Good frame, out_ready high, FIFO preloaded.
      add_good(3, 8'hAA, 8'h11);
      exp_stream(3, 8'hAA, 8'h11);
      run(45);
      check_good_hdr("good");
      check_stream("good");
      check("good_frame_cnt", 64'(m_fc), 64'd1);
      check("good_err_cnt", 64'(m_ec), 64'd0);
      check("good_ren_gap", 64'(ren_gap), 64'd0);
      check("good_no_err", 64'(code_q.size()), 64'd0);

      // Backpressure mid-payload.
      clr_mon();
      add_good(40, 8'h00, 8'h01);
      exp_stream(40, 8'h00, 8'h01);
      run(28);
      out_ready = 1'b0;
      run(6);
      out_ready = 1'b1;
      run(70);
      check_good_hdr("bp");
      check_stream("bp");
      check("bp_occ_le2", 64'(occ_max <= 2), 64'd1);
      check("bp_ren_dropped", 64'(ren_gap > 0), 64'd1);
      check("bp_hold_stable", 64'(stab_err), 64'd0);
      check("bp_frame_cnt", 64'(m_fc), 64'd2);

      // Bad SFD then a good frame.
      clr_mon();
      add(9'h055); add(9'h055); add(9'h012); add(9'h134);
      add_good(3, 8'hAA, 8'h11);
      exp_stream(3, 8'hAA, 8'h11);
      run(45);
      check("sfd_err_n", 64'(code_q.size()), 64'd1);
      check("sfd_err_code", (code_q.size() > 0) ? 64'(code_q[0]) : 64'hdead, 64'(ERR_PREAMBLE));
      check("sfd_err_cnt", 64'(m_ec), 64'd1);
      check_good_hdr("sfd");
      check_stream("sfd");
      check("sfd_frame_cnt", 64'(m_fc), 64'd3);

      // Runt: header ends on its 10th byte.
      clr_mon();
      add(9'h055); add(9'h0D5);
      for (int i = 1; i <= 10; i++) add({i == 10, 8'(i)});
      add_good(3, 8'hAA, 8'h11);
      exp_stream(3, 8'hAA, 8'h11);
      run(50);
      check("runt_err_n", 64'(code_q.size()), 64'd1);
      check("runt_err_code", (code_q.size() > 0) ? 64'(code_q[0]) : 64'hdead, 64'(ERR_RUNT));
      check("runt_err_cnt", 64'(m_ec), 64'd2);
      check_good_hdr("runt");
      check_stream("runt");
      check("runt_frame_cnt", 64'(m_fc), 64'd4);

      // Oversize on the MAX_FRAME=20 instance: 25-byte frame.
      sel_b = 1'b1;
      do_reset();
      add_good(11, 8'h30, 8'h01);
      for (int i = 0; i < 5; i++) exp_q.push_back({2'b00, 8'h30 + 8'(i)});
      exp_q.push_back({2'b11, 8'h35});
      run(50);
      check_good_hdr("ovs");
      check_stream("ovs");
      check("ovs_err_n", 64'(code_q.size()), 64'd1);
      check("ovs_err_code", (code_q.size() > 0) ? 64'(code_q[0]) : 64'hdead, 64'(ERR_OVERSIZE));
      check("ovs_err_cnt", 64'(m_ec), 64'd1);
      check("ovs_frame_cnt", 64'(m_fc), 64'd0);
      check("ovs_state", 64'(m_st), 64'(S_PREAMBLE));

      // A 17-byte frame fits under MAX_FRAME=20.
      clr_mon();
      add_good(3, 8'hAA, 8'h11);
      exp_stream(3, 8'hAA, 8'h11);
      run(45);
      check_stream("ovs_next");
      check("ovs_next_frame_cnt", 64'(m_fc), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/eth_rx_parser.md
# eth_rx_parser

Receive-side frame parser on the read side of the ingress `async_fifo`, in the `rclk` domain. Pops tagged bytes from the FIFO, checks preamble/SFD, and extracts the destination MAC, source MAC and EtherType into a one-cycle header pulse. Payload bytes go out on a valid/ready byte stream to the switch lookup/forwarding stage, and malformed frames are flagged and counted.

## Interface
- `MIN_PREAMBLE`, default 1: minimum count of 0x55 bytes required before the SFD.
- `MAX_FRAME`, default 1518: maximum frame length in bytes, counted from the first dst-MAC byte.
- `CNT_WIDTH`, default 16: width of the statistics counters.
- `rclk`  in  1  clock (single clock domain).
- `rrst_n`  in  1  asynchronous active-low reset.
- `fifo_empty`  in  1  `r_empty` of the upstream FIFO.
- `fifo_data`  in  9  `r_data` of the FIFO; [8] = last byte of frame, [7:0] = byte.
- `fifo_ren`  out  1  `r_en` to the FIFO.
- `hdr_valid`  out  1  one-cycle pulse; header fields are valid in that cycle.
- `hdr_dst_mac`  out  48  first wire byte in [47:40].
- `hdr_src_mac`  out  48  same byte order as `hdr_dst_mac`.
- `hdr_ethertype`  out  16  first wire byte in [15:8].
- `out_valid`, `out_ready`  out/in  1  payload handshake.
- `out_data`  out  8  payload byte.
- `out_last`  out  1  marks the final payload byte.
- `out_err`  out  1  qualifies `out_last`: the frame was truncated.
- `frame_err`  out  1  one-cycle pulse on a detected error.
- `err_code`  out  2  valid with `frame_err`: 0 = preamble/SFD, 1 = runt, 2 = oversize.
- `frame_cnt`  out  CNT_WIDTH  count of good frames, wraps.
- `err_cnt`  out  CNT_WIDTH  count of errored frames, wraps.

## Operation
- The FSM has four states: PREAMBLE, HEADER, PAYLOAD and DROP. Reset state is PREAMBLE.
- PREAMBLE:
  - A 0x55 byte increments `pre_cnt`, which saturates at 7.
  - 0xD5 with `pre_cnt` >= MIN_PREAMBLE moves to HEADER and sets `byte_cnt` to 0.
  - Any other byte, or 0xD5 with `pre_cnt` < MIN_PREAMBLE, raises error 0. The FSM then goes to DROP, or stays in PREAMBLE if that byte has last=1.
  - A byte with last=1 always clears `pre_cnt`.
- HEADER:
  - Bytes 0-5 shift into `dst`, bytes 6-11 into `src`, bytes 12-13 into EtherType.
  - last=1 on any header byte, including byte 13, raises error 1 (runt). The FSM returns to PREAMBLE and `hdr_valid` does not fire.
  - Byte 13 with last=0 pulses `hdr_valid` and moves to PAYLOAD.
- PAYLOAD:
  - Each byte is forwarded through the output buffer with `out_last` = fifo_data[8].
  - last=1: `frame_cnt`++ and the FSM goes to PREAMBLE.
  - When the byte's frame index equals MAX_FRAME-1 and last=0, the byte is forwarded with `out_last`=1 and `out_err`=1. Error 2 is raised and the FSM goes to DROP.
- DROP: discards bytes until last=1, then goes to PREAMBLE.
- Every error pulse increments `err_cnt` exactly once per frame.
- `byte_cnt` width is $clog2(MAX_FRAME+1).

## Timing
- The FIFO read has one cycle of latency. `fifo_ren` high in cycle t means the byte is on `fifo_data` in cycle t+1. The parser tracks this with an `inflight` flag and samples `fifo_data` only when `inflight`=1, never from a stale hold.
- Pop rule: `fifo_ren` = !fifo_empty && (occ − pop + inflight) < 2.
  - `occ` is the output-buffer occupancy (0..2).
  - `pop` = out_valid && out_ready.
  - This gives 1 byte/cycle throughput with `out_ready` held high.
- Payload latency: a byte popped in cycle t appears on `out_data` in cycle t+2.
- `hdr_valid` fires in the cycle after EtherType byte 13 is on `fifo_data`. This is at or before the first payload byte's `out_valid`.
- Output handshake: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_last` and `out_err` hold stable.
- Reset values: all outputs 0, counters 0, buffer empty, `inflight`=0.
- Reset mid-frame: the remainder of the interrupted frame appears as non-preamble bytes. It yields error 0 followed by DROP to last.

## Structure
- Package `eth_pkg` holds:
  - `parser_state_e`
  - `PREAMBLE_BYTE` = 8'h55
  - `SFD_BYTE` = 8'hD5
  - `ETH_HDR_LEN` = 14
  - `eth_err_e`
  - struct `eth_hdr_t` {dst, src, ethertype}
- Sub-module `byte_skid_fifo`: a 2-entry {err, last, data} buffer with valid/ready output and an `occ` output. All FSM, counter and pop logic stays in `eth_rx_parser`.

## Test plan
- Reset: assert `rrst_n`=0 with random inputs → all outputs 0, `fifo_ren`=0.
- Good frame with `out_ready`=1, FIFO continuously non-empty:
  - Stimulus: 55×7, D5, dst 01-02-03-04-05-06, src 0A-0B-0C-0D-0E-0F, EtherType 08 00, payload AA BB CC (CC last).
  - Response: one `hdr_valid` with dst=48'h010203040506, src=48'h0A0B0C0D0E0F, EtherType=16'h0800; output AA, BB, CC with `out_last` on CC; `frame_cnt`=1; `fifo_ren` high every cycle.
- Backpressure: same frame with 40-byte payload 00..27, `out_ready` low for 6 cycles mid-payload → `occ` never exceeds 2, `fifo_ren` drops, output is exactly 00..27 in order with no loss or duplication.
- Bad SFD: 55 55 12 34(last), then a good frame → `frame_err` with code 0 once, `err_cnt`=1, no `hdr_valid` or `out_valid` for the bad frame, and the good frame parses correctly.
- Runt: preamble + SFD, then 10 header bytes with the 10th last → code 1, no `hdr_valid`; a following good frame parses.
- Oversize with MAX_FRAME=20: 25-byte frame (14 header + 11 payload) → 6 payload bytes are forwarded, the 6th with `out_last`=1 and `out_err`=1; code 2; remaining 5 bytes dropped; `err_cnt`=1, `frame_cnt`=0.
